// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver and the 2-bit predictor it talks to.
// The counter encoding lets a predictor derive its direction from the state MSB.
package branch_pkg;

  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'd0,
    WEAK_NOT_TAKEN   = 2'd1,
    WEAK_TAKEN       = 2'd2,
    STRONG_TAKEN     = 2'd3
  } pred_state_e;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_CNT_W = 16;

  function automatic logic pred_dir(input pred_state_e s);
    return s[1];
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch / execute / predictor signals seen by the branch resolver.
// The resolver uses the slave view; the surrounding pipeline uses master.
interface branch_resolver_if
  import branch_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);
  logic             br_valid;
  logic             br_ready;
  logic             request;
  logic             prediction;
  logic             pred_valid;
  logic             pred_taken;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             result;
  logic             taken;
  logic             mispredict;
  logic             redirect_taken;
  logic [CNT_W-1:0] resolved_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output br_valid, prediction, resolve_valid, resolve_taken,
    input  br_ready, request, pred_valid, pred_taken, result, taken,
           mispredict, redirect_taken, resolved_cnt, mispred_cnt
  );

  modport slave (
    input  br_valid, prediction, resolve_valid, resolve_taken,
    output br_ready, request, pred_valid, pred_taken, result, taken,
           mispredict, redirect_taken, resolved_cnt, mispred_cnt
  );
endinterface

// File: rtl/pred_fifo.sv
// 1-bit circular FIFO holding captured predictions in program order.
// Flush has priority over push/pop and empties the queue in one edge.
module pred_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic           mem [DEPTH];
  logic [AW-1:0]  rd_q, rd_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push;
  logic           do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  assign head  = mem[rd_q];
  assign count = count_q;

endmodule

// File: rtl/branch_resolver.sv
// Issues predictor requests for fetched branches, queues the predictions and
// checks them against execute's outcomes, training the predictor and flushing on mispredicts.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_resolver_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [AW:0]      DEPTH_V = (AW+1)'(DEPTH);

  logic [AW:0]      fifo_count;
  logic             fifo_head;
  logic [AW:0]      outstanding;
  logic             br_ready;
  logic             accept;
  logic             res_legal;
  logic             bypass;
  logic             cmp_pred;
  logic             mis;
  logic             push;
  logic             pop;

  logic             pend_q, pend_d;
  logic             mispredict_q, mispredict_d;
  logic             redirect_q, redirect_d;
  logic [CNT_W-1:0] resolved_q, resolved_d;
  logic [CNT_W-1:0] mispred_q, mispred_d;

  assign outstanding = fifo_count + {{AW{1'b0}}, pend_q};
  assign br_ready    = (outstanding < DEPTH_V);
  assign accept      = bus.br_valid & br_ready;
  assign res_legal   = bus.resolve_valid & (outstanding != '0);

  // With nothing queued the oldest branch is the one being captured right now.
  assign bypass   = res_legal & (fifo_count == '0);
  assign cmp_pred = (fifo_count != '0) ? fifo_head : bus.prediction;
  assign mis      = res_legal & (cmp_pred != bus.resolve_taken);
  assign push     = pend_q & ~bypass;
  assign pop      = res_legal & ~bypass;

  always_comb begin
    pend_d       = accept & ~mis;
    mispredict_d = mis;
    redirect_d   = mis ? bus.resolve_taken : redirect_q;
    resolved_d   = resolved_q;
    mispred_d    = mispred_q;
    if (res_legal && resolved_q != CNT_MAX) resolved_d = resolved_q + 1'b1;
    if (mis && mispred_q != CNT_MAX)        mispred_d  = mispred_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= 1'b0;
      resolved_q   <= '0;
      mispred_q    <= '0;
    end else begin
      pend_q       <= pend_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      resolved_q   <= resolved_d;
      mispred_q    <= mispred_d;
    end
  end

  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.prediction),
    .pop   (pop),
    .flush (mis),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign bus.br_ready       = br_ready;
  assign bus.request        = accept;
  assign bus.pred_valid     = pend_q;
  assign bus.pred_taken     = pend_q & bus.prediction;
  assign bus.result         = res_legal;
  assign bus.taken          = bus.resolve_taken;
  assign bus.mispredict     = mispredict_q;
  assign bus.redirect_taken = redirect_q;
  assign bus.resolved_cnt   = resolved_q;
  assign bus.mispred_cnt    = mispred_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Drives two resolvers (16-bit and 2-bit counters) with identical stimulus and checks
// both against a queue model of outstanding branches.
module tb_branch_resolver;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic br_valid = 1'b0, prediction = 1'b0, resolve_valid = 1'b0, resolve_taken = 1'b0;

  int errors = 0;
  int checks = 0;

  // Model: one entry per outstanding branch, oldest first; 2 = prediction not yet returned.
  int mq[$];
  bit exp_mis = 1'b0, exp_redir = 1'b0;
  int nres = 0, nmp = 0;

  always #5 clk = ~clk;

  branch_resolver_if #(.CNT_W(16)) b16 ();
  branch_resolver_if #(.CNT_W(2))  b2 ();

  assign b16.br_valid = br_valid;      assign b2.br_valid = br_valid;
  assign b16.prediction = prediction;  assign b2.prediction = prediction;
  assign b16.resolve_valid = resolve_valid; assign b2.resolve_valid = resolve_valid;
  assign b16.resolve_taken = resolve_taken; assign b2.resolve_taken = resolve_taken;

  branch_resolver #(.DEPTH(DEPTH), .CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
  branch_resolver #(.DEPTH(DEPTH), .CNT_W(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic chk_regs();
    chk("mispredict16", 32'(b16.mispredict), 32'(exp_mis));
    chk("mispredict2", 32'(b2.mispredict), 32'(exp_mis));
    if (exp_mis) chk("redirect_taken", 32'(b16.redirect_taken), 32'(exp_redir));
    chk("resolved_cnt16", 32'(b16.resolved_cnt), 32'(sat(nres, 65535)));
    chk("mispred_cnt16", 32'(b16.mispred_cnt), 32'(sat(nmp, 65535)));
    chk("resolved_cnt2", 32'(b2.resolved_cnt), 32'(sat(nres, 3)));
    chk("mispred_cnt2", 32'(b2.mispred_cnt), 32'(sat(nmp, 3)));
  endtask

  task automatic step(input bit bv, input bit pr, input bit rv, input bit rt);
    int n;
    bit e_ready, e_req, e_res, e_pv, cmp, mis;
    @(negedge clk);
    br_valid = bv; prediction = pr; resolve_valid = rv; resolve_taken = rt;
    #1;
    n       = mq.size();
    e_ready = (n < DEPTH);
    e_req   = bv && e_ready;
    e_res   = rv && (n > 0);
    e_pv    = (n > 0) && (mq[n-1] == 2);
    chk_regs();
    chk("br_ready", 32'(b16.br_ready), 32'(e_ready));
    chk("request", 32'(b16.request), 32'(e_req));
    chk("pred_valid", 32'(b16.pred_valid), 32'(e_pv));
    chk("pred_taken", 32'(b16.pred_taken), 32'(e_pv && pr));
    chk("result", 32'(b16.result), 32'(e_res));
    chk("taken", 32'(b16.taken), 32'(rt));
    chk("result2", 32'(b2.result), 32'(e_res));
    $display("step bv=%0d pr=%0d rv=%0d rt=%0d outstanding=%0d", bv, pr, rv, rt, n);
    mis = 1'b0;
    if (e_res) begin
      cmp = (mq[0] == 2) ? pr : (mq[0] == 1);
      mis = (cmp != rt);
      void'(mq.pop_front());
      nres++;
    end
    if (mis) begin
      mq.delete();
      nmp++;
      exp_redir = rt;
    end else if (mq.size() > 0 && mq[mq.size()-1] == 2) begin
      mq[mq.size()-1] = int'(pr);
    end
    if (e_req && !mis) mq.push_back(2);
    exp_mis = mis;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    br_valid = 1'b0; resolve_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_br_ready", 32'(b16.br_ready), 32'd1);
    chk("rst_mispredict", 32'(b16.mispredict), 32'd0);
    chk("rst_pred_valid", 32'(b16.pred_valid), 32'd0);
    chk("rst_resolved", 32'(b16.resolved_cnt), 32'd0);
    chk("rst_mispred", 32'(b16.mispred_cnt), 32'd0);
    chk("rst_resolved2", 32'(b2.resolved_cnt), 32'd0);
    $display("reset asserted");
    mq.delete(); exp_mis = 1'b0; exp_redir = 1'b0; nres = 0; nmp = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // Illegal resolve with nothing outstanding.
    step(0, 0, 1, 0);
    // Single branch, predicted taken, resolved taken.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    // Fill four back-to-back (predictions 1,0,1,1), then resolve 1,0,1,0.
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    // Bypass: resolve in the capture cycle.
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    // Flush with a simultaneous accept being squashed.
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    // Repeated bypass mispredicts drive the 2-bit counters into saturation.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      step(0, 1, 1, 0);
    end
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    // Reset with three branches outstanding.
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    do_reset();
    step(0, 0, 1, 1);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
    end
    step(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
